// File: rtl/sc_phase_gen.sv
// Two-phase non-overlapping clock generator (phi1/phi2) with sample strobe and period counter.
// Define SC_PHASE_EARLY_EN to add early-falling phases o_phi1e/o_phi2e (minimum phase width becomes 2).
//
//   state  | meaning
//   IDLE   | stopped, waiting for i_en
//   PH1    | phi1 high for H cycles
//   GAP12  | dead time after phi1, D cycles
//   PH2    | phi2 high for H cycles
//   GAP21  | dead time after phi2, D cycles; period end
module sc_phase_gen #(
  parameter int DIV_W = 8,
  parameter int DT_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_half_period,
  input  logic [DT_W-1:0]  i_dead_time,
  output logic             o_phi1,
  output logic             o_phi2,
  output logic             o_sample_strobe,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic             o_busy
`ifdef SC_PHASE_EARLY_EN
  ,
  output logic             o_phi1e,
  output logic             o_phi2e
`endif
);

`ifdef SC_PHASE_EARLY_EN
  localparam logic [DIV_W-1:0] H_MIN = DIV_W'(2);
`else
  localparam logic [DIV_W-1:0] H_MIN = DIV_W'(1);
`endif

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_PH1   = 5'b00010,
    S_GAP12 = 5'b00100,
    S_PH2   = 5'b01000,
    S_GAP21 = 5'b10000
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_h;
  logic [DT_W-1:0]  r_d;
  logic             r_strobe;
  logic [CNT_W-1:0] r_pcnt;
  logic             r_busy;
`ifdef SC_PHASE_EARLY_EN
  logic             r_phi1e;
  logic             r_phi2e;
`endif

  logic [DIV_W-1:0] w_h_eff;
  logic [DT_W-1:0]  w_d_eff;
  logic [DIV_W-1:0] w_d_m1;
  logic             w_cnt_zero;

  // Gap counts are zero-extended into the phase counter, so DT_W must not exceed DIV_W.
  assign w_h_eff    = (i_half_period < H_MIN) ? H_MIN : i_half_period;
  assign w_d_eff    = (i_dead_time == '0) ? DT_W'(1) : i_dead_time;
  assign w_d_m1     = DIV_W'(r_d - DT_W'(1));
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_h      <= DIV_W'(1);
      r_d      <= DT_W'(1);
      r_strobe <= 1'b0;
      r_pcnt   <= '0;
      r_busy   <= 1'b0;
`ifdef SC_PHASE_EARLY_EN
      r_phi1e  <= 1'b0;
      r_phi2e  <= 1'b0;
`endif
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_en) begin
            r_state <= S_PH1;
            r_h     <= w_h_eff;
            r_d     <= w_d_eff;
            r_cnt   <= w_h_eff - DIV_W'(1);
            r_busy  <= 1'b1;
`ifdef SC_PHASE_EARLY_EN
            r_phi1e <= 1'b1;
`endif
          end
        end
        S_PH1: begin
          if (w_cnt_zero) begin
            r_state <= S_GAP12;
            r_cnt   <= w_d_m1;
          end else begin
            r_cnt   <= r_cnt - DIV_W'(1);
          end
`ifdef SC_PHASE_EARLY_EN
          r_phi1e <= !w_cnt_zero && (r_cnt != DIV_W'(1));
`endif
        end
        S_GAP12: begin
          if (w_cnt_zero) begin
            r_state <= S_PH2;
            r_cnt   <= r_h - DIV_W'(1);
`ifdef SC_PHASE_EARLY_EN
            r_phi2e <= 1'b1;
`endif
          end else begin
            r_cnt   <= r_cnt - DIV_W'(1);
          end
        end
        S_PH2: begin
          if (w_cnt_zero) begin
            r_state  <= S_GAP21;
            r_cnt    <= w_d_m1;
            r_strobe <= 1'b1;
          end else begin
            r_cnt    <= r_cnt - DIV_W'(1);
          end
`ifdef SC_PHASE_EARLY_EN
          r_phi2e <= !w_cnt_zero && (r_cnt != DIV_W'(1));
`endif
        end
        S_GAP21: begin
          if (w_cnt_zero) begin
            r_pcnt <= r_pcnt + CNT_W'(1);
            // New configuration is only picked up here, at the period boundary.
            if (i_en) begin
              r_state <= S_PH1;
              r_h     <= w_h_eff;
              r_d     <= w_d_eff;
              r_cnt   <= w_h_eff - DIV_W'(1);
`ifdef SC_PHASE_EARLY_EN
              r_phi1e <= 1'b1;
`endif
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_phi1          = r_state[1];
  assign o_phi2          = r_state[3];
  assign o_sample_strobe = r_strobe;
  assign o_period_cnt    = r_pcnt;
  assign o_busy          = r_busy;
`ifdef SC_PHASE_EARLY_EN
  assign o_phi1e         = r_phi1e;
  assign o_phi2e         = r_phi2e;
`endif

endmodule

// File: tb/tb_sc_phase_gen.sv
// Directed bench for sc_phase_gen; per-cycle traces packed into bit vectors and compared to hand-built patterns.
module tb_sc_phase_gen;
  localparam int DIV_W = 8;
  localparam int DT_W  = 4;
  localparam int CNT_W = 4;
`ifdef SC_PHASE_EARLY_EN
  localparam int P0 = 6;
`else
  localparam int P0 = 4;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [DIV_W-1:0] hp  = '0;
  logic [DT_W-1:0]  dt  = '0;
  logic             phi1, phi2, strobe, busy;
  logic [CNT_W-1:0] pcnt;
`ifdef SC_PHASE_EARLY_EN
  logic             phi1e, phi2e;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sc_phase_gen #(.DIV_W(DIV_W), .DT_W(DT_W), .CNT_W(CNT_W)) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_half_period  (hp),
    .i_dead_time    (dt),
    .o_phi1         (phi1),
    .o_phi2         (phi2),
    .o_sample_strobe(strobe),
    .o_period_cnt   (pcnt),
    .o_busy         (busy)
`ifdef SC_PHASE_EARLY_EN
    ,
    .o_phi1e        (phi1e),
    .o_phi2e        (phi2e)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en  = 1'b0;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic capture(input int n, output logic [31:0] p1, output logic [31:0] p2,
                         output logic [31:0] st, output logic [31:0] bz);
    p1 = '0; p2 = '0; st = '0; bz = '0;
    for (int c = 0; c < n; c++) begin
      step;
      p1[c] = phi1;
      p2[c] = phi2;
      st[c] = strobe;
      bz[c] = busy;
    end
  endtask

  // phases must never overlap, checked every cycle
  always @(negedge clk) check_val("no_overlap", {31'd0, phi1 & phi2}, 32'd0);

  logic [31:0] p1, p2, st, bz;

  initial begin
    // basic period, H=3 D=1
    do_reset;
    check_val("rst_phi1",   {31'd0, phi1},   32'd0);
    check_val("rst_phi2",   {31'd0, phi2},   32'd0);
    check_val("rst_strobe", {31'd0, strobe}, 32'd0);
    check_val("rst_busy",   {31'd0, busy},   32'd0);
    check_val("rst_pcnt",   {28'd0, pcnt},   32'd0);
    hp = 8'd3; dt = 4'd1; en = 1'b1;
    capture(8, p1, p2, st, bz);
    check_val("h3_phi1",   p1, 32'h07);
    check_val("h3_phi2",   p2, 32'h70);
    check_val("h3_strobe", st, 32'h80);
    check_val("h3_busy",   bz, 32'hFF);
    check_val("h3_pcnt_pre", {28'd0, pcnt}, 32'd0);
    step;
    check_val("h3_pcnt", {28'd0, pcnt}, 32'd1);
    check_val("h3_next_phi1", {31'd0, phi1}, 32'd1);

    // zero configuration is clamped
    do_reset;
    hp = 8'd0; dt = 4'd0; en = 1'b1;
    capture(8, p1, p2, st, bz);
`ifdef SC_PHASE_EARLY_EN
    check_val("h0_phi1",   p1, 32'hC3);
    check_val("h0_phi2",   p2, 32'h18);
    check_val("h0_strobe", st, 32'h20);
`else
    check_val("h0_phi1",   p1, 32'h11);
    check_val("h0_phi2",   p2, 32'h44);
    check_val("h0_strobe", st, 32'h88);
`endif
    check_val("h0_pcnt", {28'd0, pcnt}, 32'd1);

    // half_period changed during PH2 only affects the next period
    do_reset;
    hp = 8'd3; dt = 4'd1; en = 1'b1;
    p1 = '0; p2 = '0; st = '0;
    for (int c = 0; c < 16; c++) begin
      step;
      p1[c] = phi1;
      p2[c] = phi2;
      st[c] = strobe;
      if (c == 4) hp = 8'd5;
    end
    check_val("chg_phi1",   p1, 32'h1F07);
    check_val("chg_phi2",   p2, 32'hC070);
    check_val("chg_strobe", st, 32'h0080);

    // en dropped during PH1 completes the period, then idles
    do_reset;
    hp = 8'd2; dt = 4'd2; en = 1'b1;
    p1 = '0; p2 = '0; st = '0; bz = '0;
    for (int c = 0; c < 12; c++) begin
      step;
      p1[c] = phi1;
      p2[c] = phi2;
      st[c] = strobe;
      bz[c] = busy;
      if (c == 0) en = 1'b0;
    end
    check_val("stop_phi1",   p1, 32'h003);
    check_val("stop_phi2",   p2, 32'h030);
    check_val("stop_strobe", st, 32'h040);
    check_val("stop_busy",   bz, 32'h0FF);
    check_val("stop_pcnt",   {28'd0, pcnt}, 32'd1);

    // reset in the middle of PH2 of the second period
    do_reset;
    hp = 8'd3; dt = 4'd1; en = 1'b1;
    repeat (14) step;
    check_val("mid_phi2", {31'd0, phi2}, 32'd1);
    check_val("mid_pcnt", {28'd0, pcnt}, 32'd1);
    rst = 1'b1;
    step;
    check_val("mrst_phi2", {31'd0, phi2}, 32'd0);
    check_val("mrst_phi1", {31'd0, phi1}, 32'd0);
    check_val("mrst_pcnt", {28'd0, pcnt}, 32'd0);
    check_val("mrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step;
    check_val("restart_phi1", {31'd0, phi1}, 32'd1);
    capture(3, p1, p2, st, bz);
    check_val("restart_width", p1, 32'h3);

    // period counter wrap at CNT_W=4
    do_reset;
    hp = 8'd0; dt = 4'd0; en = 1'b1;
    repeat (15 * P0 + 1) step;
    check_val("wrap_15", {28'd0, pcnt}, 32'd15);
    repeat (P0 - 1) step;
    check_val("wrap_15_end", {28'd0, pcnt}, 32'd15);
    step;
    check_val("wrap_0", {28'd0, pcnt}, 32'd0);

`ifdef SC_PHASE_EARLY_EN
    do_reset;
    hp = 8'd3; dt = 4'd1; en = 1'b1;
    p1 = '0; p2 = '0;
    for (int c = 0; c < 8; c++) begin
      step;
      p1[c] = phi1e;
      p2[c] = phi2e;
    end
    check_val("early_phi1e", p1, 32'h03);
    check_val("early_phi2e", p2, 32'h30);
`endif

    en = 1'b0;
    step;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
